// File: rtl/rfphoenix_icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rfphoenix_icache_ctrl
// Brief    : I-cache hit detect, victim selection and burst refill controller.
// Revision : 1.0
// ============================================================================
module rfphoenix_icache_ctrl #(
    parameter int AWID  = 32,
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int BEATS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AWID-1:0]           ip,
    input  logic                      ip_v,
    output logic [6:0]                ndx,
    input  logic [WAYS*(AWID-7)-1:0]  tag,
    output logic                      ihit,
    output logic [1:0]                hit_way,
    output logic                      stall,
    output logic                      mreq,
    output logic [AWID-1:0]           madr,
    input  logic                      mack,
    input  logic [127:0]              mdat,
    input  logic                      merr,
    output logic                      tag_wr,
    output logic [1:0]                tag_way,
    output logic [AWID-1:0]           tag_ipo,
    output logic                      line_wr,
    output logic [BEATS*128-1:0]      line_dat,
    output logic                      ierr,
    input  logic                      inv_all
);

    localparam int TW = AWID - 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_FILL = 3'd2,
        S_WRT  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [AWID-1:0]        ip_r_q;
    logic                   ipv_r_q;
    logic [WAYS-1:0]        valid_q [LINES];
    logic [1:0]             rr_q    [LINES];
    logic [2:0]             cnt_q;
    logic [BEATS*128-1:0]   line_q;
    logic [AWID-1:0]        madr_q;
    logic [1:0]             victim_q;
    logic                   stale_q;
    logic                   ierr_q;

    logic [6:0]             w_idx;
    logic [6:0]             w_fill_idx;
    logic [WAYS-1:0]        w_hitv;
    logic [1:0]             w_hit_way;
    logic [1:0]             w_victim;
    logic                   w_miss;
    logic                   w_unused;

    assign w_idx      = ip_r_q[13:7];
    assign w_fill_idx = madr_q[13:7];
    assign w_unused   = ^ip_r_q[6:0];

    // Victim prefers the lowest invalid way; round-robin only when the set is full.
    always_comb begin
        w_hitv    = '0;
        w_hit_way = 2'd0;
        w_victim  = rr_q[w_idx];
        for (int w = 0; w < WAYS; w++) begin
            w_hitv[w] = (tag[w*TW +: TW] == ip_r_q[AWID-1:7]) && valid_q[w_idx][w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hitv[w]) begin
                w_hit_way = 2'(w);
            end
            if (!valid_q[w_idx][w]) begin
                w_victim = 2'(w);
            end
        end
    end

    assign w_miss = ipv_r_q && (w_hitv == '0) && (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        ndx      = ip[13:7];
        ihit     = 1'b0;
        hit_way  = 2'd0;
        stall    = 1'b0;
        mreq     = 1'b0;
        madr     = madr_q;
        tag_wr   = 1'b0;
        line_wr  = 1'b0;
        tag_way  = victim_q;
        tag_ipo  = madr_q;
        line_dat = line_q;
        ierr     = ierr_q;
        case (state_q)
            S_IDLE: begin
                ihit    = ipv_r_q && (w_hitv != '0);
                hit_way = ihit ? w_hit_way : 2'd0;
                stall   = w_miss;
                if (w_miss) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                stall   = 1'b1;
                mreq    = 1'b1;
                state_d = S_FILL;
            end
            S_FILL: begin
                stall = 1'b1;
                mreq  = 1'b1;
                if (mack) begin
                    if (merr) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == 3'(BEATS - 1)) begin
                        state_d = S_WRT;
                    end
                end
            end
            S_WRT: begin
                stall   = 1'b1;
                tag_wr  = 1'b1;
                line_wr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ip_r_q   <= '0;
            ipv_r_q  <= 1'b0;
            cnt_q    <= 3'd0;
            line_q   <= '0;
            madr_q   <= '0;
            victim_q <= 2'd0;
            stale_q  <= 1'b0;
            ierr_q   <= 1'b0;
            for (int l = 0; l < LINES; l++) begin
                valid_q[l] <= '0;
                rr_q[l]    <= 2'd0;
            end
        end else begin
            state_q <= state_d;
            ierr_q  <= (state_q == S_FILL) && mack && merr;

            if ((state_q == S_IDLE) && !w_miss) begin
                ip_r_q  <= ip;
                ipv_r_q <= ip_v;
            end

            if (w_miss) begin
                madr_q   <= {ip_r_q[AWID-1:7], 7'b0};
                victim_q <= w_victim;
                stale_q  <= 1'b0;
                cnt_q    <= 3'd0;
            end

            if ((state_q == S_FILL) && mack) begin
                if (merr) begin
                    cnt_q <= 3'd0;
                end else begin
                    line_q[{cnt_q, 7'd0} +: 128] <= mdat;
                    cnt_q <= cnt_q + 3'd1;
                end
            end

            if (state_q == S_WRT) begin
                rr_q[w_fill_idx] <= rr_q[w_fill_idx] + 2'd1;
                if (!stale_q) begin
                    valid_q[w_fill_idx][victim_q] <= 1'b1;
                end
            end

            // Placed last so a coincident invalidate overrides the WRT valid set.
            if (inv_all) begin
                for (int l = 0; l < LINES; l++) begin
                    valid_q[l] <= '0;
                end
                if ((state_q == S_REQ) || (state_q == S_FILL) || (state_q == S_WRT)) begin
                    stale_q <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
